// File: rtl/accl_pair_scheduler.sv
// Walks every ordered body pair (i, j) for one force pass, drives the body-RAM
// read addresses and tags each pair through a delay line matched to RAM + getAccl latency.
module accl_pair_scheduler #(
  parameter  int N_MAX    = 16,
  parameter  int RD_LAT   = 1,
  parameter  int ACCL_LAT = 123,
  localparam int IDX_W    = $clog2(N_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   n_bodies,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_addr_i,
  output logic [IDX_W-1:0] rd_addr_j,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_idx_i,
  output logic [IDX_W-1:0] res_idx_j,
  output logic             res_first,
  output logic             res_last
);

  localparam int DEPTH = RD_LAT + ACCL_LAT;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic             first;
    logic             last;
  } tag_t;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W:0]   n_q, n_d;
  tag_t [DEPTH-1:0] line_q, line_d;

  tag_t             tag_in;
  tag_t             tag_out;
  logic             issue;
  logic             last_pair;
  logic [IDX_W-1:0] n_last;
  logic [IDX_W:0]   n_clamp;

  assign n_clamp   = (n_bodies > (IDX_W+1)'(N_MAX)) ? (IDX_W+1)'(N_MAX) : n_bodies;
  assign n_last    = IDX_W'(n_q - (IDX_W+1)'(1));
  assign issue     = (state_q == S_ISSUE) && !hold;
  assign last_pair = (i_q == n_last) && (j_q == n_last);
  assign tag_out   = line_q[DEPTH-1];

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    n_d     = n_q;
    tag_in  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n_clamp;
          i_d     = '0;
          j_d     = '0;
          state_d = (n_clamp == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          tag_in = '{valid: 1'b1, i: i_q, j: j_q,
                     first: (j_q == '0), last: (j_q == n_last)};
          if (j_q == n_last) begin
            j_d = '0;
            i_d = i_q + IDX_W'(1);
          end else begin
            j_d = j_q + IDX_W'(1);
          end
          if (last_pair) begin
            i_d     = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // the final pair reaching the line output marks the end of the pass
        if (tag_out.valid && tag_out.last && (tag_out.i == n_last)) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    line_d = {line_q[DEPTH-2:0], tag_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      n_q     <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      n_q     <= n_d;
      line_q  <= line_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign rd_en     = issue;
  assign rd_addr_i = i_q;
  assign rd_addr_j = j_q;
  assign res_valid = tag_out.valid;
  assign res_idx_i = tag_out.i;
  assign res_idx_j = tag_out.j;
  assign res_first = tag_out.first;
  assign res_last  = tag_out.last;

endmodule

// File: doc/accl_pair_scheduler.md
Name: accl_pair_scheduler

Overview:
- Sequences the pairwise gravitational-acceleration pipeline (getAccl) for one N-body force pass.
- Walks every ordered body pair (i, j) and drives the body-memory read addresses. Memory data feeds the acceleration pipeline directly.
- Tags each issued pair through a delay line matched to the memory plus pipeline latency, so the downstream accumulator knows which body each ax/ay result belongs to.
- Sits between the host/top-level step controller and the body RAM, acceleration pipeline and accumulator.

Parameters:
- N_MAX, 16, maximum number of bodies; IDX_W = $clog2(N_MAX).
- RD_LAT, 1, body-memory read latency in cycles (synchronous RAM).
- ACCL_LAT, 123, acceleration pipeline latency: 1 input register + AddTime 20 + MultTime 11 + AddTime 20 + InvSqrtTime 27 + 4 × MultTime 11.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  begin a pass; sampled only in IDLE
- n_bodies  in  IDX_W+1  body count for the pass; sampled with start
- hold  in  1  stall issue for one cycle; does not stall in-flight results
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse when the last result has emerged
- rd_en  out  1  read strobe to body RAM (both ports)
- rd_addr_i  out  IDX_W  address of body i (x1, y1)
- rd_addr_j  out  IDX_W  address of body j (x2, y2, m2)
- res_valid  out  1  ax/ay at pipeline output belong to a pair this cycle
- res_idx_i  out  IDX_W  body receiving the acceleration
- res_idx_j  out  IDX_W  source body
- res_first  out  1  res_idx_j == 0 (accumulator loads instead of adds)
- res_last  out  1  res_idx_j == n-1 (accumulated value for i is final)

Behaviour:
- Reset (rst = 0, asynchronous):
  - FSM to IDLE; counters i, j and the stored count cleared.
  - Whole tag delay line cleared.
  - All outputs 0.
  - Reset mid-pass abandons the pass: no res_valid and no done until the next start.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: busy = 0. On start:
    - n_eff = min(n_bodies, N_MAX) is latched.
    - n_eff == 0 → FIN (no reads issued).
    - Otherwise → ISSUE with i = j = 0.
  - ISSUE, each cycle with hold = 0:
    - rd_en = 1, rd_addr_i = i, rd_addr_j = j.
    - A tag {valid = 1, i, j, first, last} is pushed into the delay line.
    - j increments; when j == n_eff-1, j wraps to 0 and i increments.
    - After pair (n_eff-1, n_eff-1) → DRAIN.
  - ISSUE with hold = 1: rd_en = 0, an invalid tag is pushed, counters frozen.
  - DRAIN: rd_en = 0, invalid tags pushed. Leaves for FIN in the cycle the tag with i = j = n_eff-1 appears at the line output (res_valid = 1, res_last = 1).
  - FIN: done = 1 for exactly one cycle → IDLE.
- busy = 1 in ISSUE, DRAIN and FIN.
- start while busy is ignored. n_bodies changes after sampling are ignored.
- Self pairs (i == j) are issued. The pipeline returns zero acceleration for them and the scheduler treats them as normal pairs.
- Tag delay line:
  - Depth RD_LAT + ACCL_LAT, shift every cycle unconditionally (the acceleration pipeline has no stall).
  - The output tag drives res_valid, res_idx_i, res_idx_j, res_first and res_last directly (registered, no combinational path from inputs).
- Timing, start high in cycle 0, hold = 0:
  - First rd_en in cycle 1.
  - First res_valid in cycle 1 + RD_LAT + ACCL_LAT = 125.
  - Pairs issued n² consecutive cycles.
  - Last res_valid in cycle n² + 124.
  - done in cycle n² + 125.
- Ordering: results emerge in issue order (i-major, j-minor), each pair exactly once. res_valid is never high outside a pass.
- hold during DRAIN or IDLE has no effect.

Test Plan:
- n_bodies = 4, start in cycle 0, hold = 0:
  - rd_en high in cycles 1-16 with (i, j) = (0,0), (0,1) … (3,3).
  - res_valid in cycles 125-140 with the same tags.
  - res_first in cycles 125/129/133/137; res_last in cycles 128/132/136/140.
  - done in cycle 141 only; busy high in cycles 1-141.
- n_bodies = 3, hold high in cycles 3-4:
  - rd_en low in cycles 3-4; the 9 pairs issue in cycles 1-2 and 5-11.
  - res_valid gaps in cycles 127-128 mirror the hold.
  - done in cycle 136.
- n_bodies = 0: no rd_en, no res_valid; busy and done high in cycle 1 only.
- n_bodies = 20 with N_MAX = 16: clamped to 16; 256 pairs issued; last tag (15,15); done in cycle 381.
- start pulsed again in cycle 50 of an n = 4 pass: ignored; result stream and done timing identical to the first scenario.
- rst driven low in cycle 130 of an n = 4 pass, released in cycle 132:
  - Outputs 0 immediately.
  - No res_valid or done afterwards.
  - A new start in cycle 140 runs a clean pass (first res_valid in cycle 265).
